pc_unit: RTL and testbench
==========================

// Module: pc_unit
// PURPOSE
//  Parametrised program-counter unit; successor to the plain PC register. Holds the fetch
//  address, auto-increments on fetch acceptance, applies redirects (trap, return, jump,
//  branch) by fixed priority, saves a trap return address and supports halt/resume.
//  Sits between the execute/branch logic and the instruction-fetch port.
// PARAMETERS
//  XLEN         32            address width
//  RESET_VECTOR 32'h0000_0000 PC value after reset
//  TRAP_VECTOR  32'h0000_0100 PC value on trap entry
//  INC          4             increment per accepted fetch
//  ALIGN_BITS   2             low target bits that must be zero (legal alignment)
// PORTS
//  clk           in   1     clock, all state updates on rising edge
//  rst           in   1     synchronous reset, active-high
//  stall         in   1     hold PC; blocks increment, not redirects
//  halt          in   1     request halt (enter HALT)
//  resume        in   1     leave HALT, continue at held PC
//  branch_taken  in   1     branch redirect request
//  branch_target in   XLEN  branch destination
//  jump          in   1     jump redirect request
//  jump_target   in   XLEN  jump destination
//  trap          in   1     trap request; save PC, go to TRAP_VECTOR
//  trap_ret      in   1     return from trap to saved epc
//  pc_ready      in   1     fetch stage accepts pc_o this cycle
//  pc_o          out  XLEN  current fetch address (registered)
//  pc_valid      out  1     pc_o is a valid fetch request
//  epc_o         out  XLEN  saved trap return address (registered)
//  misalign_err  out  1     1-cycle pulse: redirect target misaligned, trap taken instead
//  halted        out  1     high while in HALT
// BEHAVIOUR
//  - Reset (rst=1 at edge): pc_o=RESET_VECTOR, epc_o=0, pc_valid=0, misalign_err=0,
//    halted=0, state=BOOT. rst dominates every other input, including mid-redirect.
//  - States: BOOT -> RUN unconditionally next cycle (pc_valid goes 1 there).
//    RUN -> HALT when halt=1 and no redirect that cycle; HALT -> RUN when resume=1.
//    In HALT: pc_valid=0, halted=1, pc_o frozen; trap still accepted (-> RUN at TRAP_VECTOR).
//  - Priority in RUN, per cycle, highest first:
//    trap > trap_ret > jump > branch_taken > halt > advance > hold.
//  - trap: epc_o<=pc_o; pc_o<=TRAP_VECTOR. trap_ret: pc_o<=epc_o, epc_o unchanged.
//  - jump/branch: if target[ALIGN_BITS-1:0]==0, pc_o<=target; else treat as trap
//    (epc_o<=pc_o, pc_o<=TRAP_VECTOR) and pulse misalign_err for exactly one cycle.
//    ALIGN_BITS=0 disables the check.
//  - Redirect latency: request in cycle N -> new pc_o visible in N+1. Redirects ignore
//    stall and pc_ready; the in-flight address is discarded (pc_valid stays 1).
//  - advance: pc_valid & pc_ready & ~stall -> pc_o<=pc_o+INC, modulo 2^XLEN
//    (0xFFFF_FFFC+4 wraps to 0x0000_0000, no flag).
//  - hold: otherwise pc_o unchanged; pc_valid held, pc_o stable while pc_valid & ~pc_ready.
//  - Simultaneous halt+resume in HALT: resume wins. halt with a redirect: redirect taken,
//    halt ignored that cycle (re-sampled next cycle).
//  - trap_ret with trap same cycle: trap wins, epc_o overwritten with current pc_o.
// TESTING
//  1 rst 3 cycles, release -> pc_o=RESET_VECTOR, pc_valid 0 one cycle then 1, epc_o=0.
//  2 pc_ready=1 x4 from 0 -> pc_o 0,4,8,C,10; stall=1 one cycle -> pc_o holds, then resumes.
//  3 pc_o=0x40, jump=1 target 0x200 plus branch_taken target 0x80 -> pc_o=0x200 next cycle.
//  4 pc_o=0x44, branch_taken target 0x81 -> pc_o=0x100, epc_o=0x44, misalign_err 1 cycle;
//    then trap_ret -> pc_o=0x44.
//  5 pc_o=0xFFFF_FFFC, pc_ready=1 -> pc_o=0x0000_0000.
//  6 halt=1 at pc 0x20 -> halted=1, pc_valid=0, pc_o=0x20 frozen; resume=1 -> RUN at 0x20;
//    rst asserted during HALT -> BOOT, pc_o=RESET_VECTOR.

Source files
------------

// File: rtl/pc_unit_if.sv
// Fetch-address bus between the execute/branch logic and the program-counter unit.
// The master modport is the PC unit's view; the slave modport is the requesting side.
interface pc_unit_if #(
  parameter int XLEN = 32
);
  logic            stall;
  logic            halt;
  logic            resume;
  logic            branch_taken;
  logic [XLEN-1:0] branch_target;
  logic            jump;
  logic [XLEN-1:0] jump_target;
  logic            trap;
  logic            trap_ret;
  logic            pc_ready;
  logic [XLEN-1:0] pc_o;
  logic            pc_valid;
  logic [XLEN-1:0] epc_o;
  logic            misalign_err;
  logic            halted;

  modport master (
    input  stall, halt, resume, branch_taken, branch_target,
           jump, jump_target, trap, trap_ret, pc_ready,
    output pc_o, pc_valid, epc_o, misalign_err, halted
  );

  modport slave (
    output stall, halt, resume, branch_taken, branch_target,
           jump, jump_target, trap, trap_ret, pc_ready,
    input  pc_o, pc_valid, epc_o, misalign_err, halted
  );
endinterface

// File: rtl/pc_unit.sv
// Program-counter unit: fetch address register with auto-increment, prioritised
// redirects (trap > trap_ret > jump > branch), trap return address and halt/resume.
module pc_unit #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100,
  parameter int              INC          = 4,
  parameter int              ALIGN_BITS   = 2
) (
  input  logic          clk,
  input  logic          rst,
  pc_unit_if.master     bus
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  localparam logic [XLEN-1:0] ZERO       = {XLEN{1'b0}};
  localparam logic [XLEN-1:0] INC_W      = XLEN'(INC);
  // A zero-width alignment field yields an all-zero mask, which disables the check.
  localparam logic [XLEN-1:0] ALIGN_MASK = (XLEN'(1'b1) << ALIGN_BITS) - XLEN'(1'b1);

  function automatic logic is_aligned(input logic [XLEN-1:0] target);
    return (target & ALIGN_MASK) == ZERO;
  endfunction

  state_e          state_r, state_nx_s;
  logic [XLEN-1:0] pc_r, pc_nx_s;
  logic [XLEN-1:0] epc_r, epc_nx_s;
  logic            valid_r, valid_nx_s;
  logic            halted_r, halted_nx_s;
  logic            misalign_r, misalign_nx_s;
  logic            redirect_s;
  logic [XLEN-1:0] target_s;

  assign redirect_s = bus.jump | bus.branch_taken;
  assign target_s   = bus.jump ? bus.jump_target : bus.branch_target;

  // Next-state, next-PC and output decode in fixed priority order.
  always_comb begin
    state_nx_s    = state_r;
    pc_nx_s       = pc_r;
    epc_nx_s      = epc_r;
    valid_nx_s    = valid_r;
    halted_nx_s   = halted_r;
    misalign_nx_s = 1'b0;
    case (state_r)
      ST_BOOT: begin
        state_nx_s  = ST_RUN;
        valid_nx_s  = 1'b1;
        halted_nx_s = 1'b0;
      end
      ST_RUN: begin
        valid_nx_s  = 1'b1;
        halted_nx_s = 1'b0;
        if (bus.trap) begin
          epc_nx_s = pc_r;
          pc_nx_s  = TRAP_VECTOR;
        end else if (bus.trap_ret) begin
          pc_nx_s = epc_r;
        end else if (redirect_s) begin
          // A misaligned target becomes a trap on the current PC.
          if (is_aligned(target_s)) begin
            pc_nx_s = target_s;
          end else begin
            epc_nx_s      = pc_r;
            pc_nx_s       = TRAP_VECTOR;
            misalign_nx_s = 1'b1;
          end
        end else if (bus.halt) begin
          state_nx_s  = ST_HALT;
          valid_nx_s  = 1'b0;
          halted_nx_s = 1'b1;
        end else if (valid_r && bus.pc_ready && !bus.stall) begin
          pc_nx_s = pc_r + INC_W;
        end else begin
          pc_nx_s = pc_r;
        end
      end
      ST_HALT: begin
        if (bus.trap) begin
          epc_nx_s    = pc_r;
          pc_nx_s     = TRAP_VECTOR;
          state_nx_s  = ST_RUN;
          valid_nx_s  = 1'b1;
          halted_nx_s = 1'b0;
        end else if (bus.resume) begin
          state_nx_s  = ST_RUN;
          valid_nx_s  = 1'b1;
          halted_nx_s = 1'b0;
        end else begin
          state_nx_s  = ST_HALT;
          valid_nx_s  = 1'b0;
          halted_nx_s = 1'b1;
        end
      end
      default: begin
        state_nx_s  = ST_BOOT;
        pc_nx_s     = RESET_VECTOR;
        valid_nx_s  = 1'b0;
        halted_nx_s = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_BOOT;
      pc_r       <= RESET_VECTOR;
      epc_r      <= ZERO;
      valid_r    <= 1'b0;
      halted_r   <= 1'b0;
      misalign_r <= 1'b0;
    end else begin
      state_r    <= state_nx_s;
      pc_r       <= pc_nx_s;
      epc_r      <= epc_nx_s;
      valid_r    <= valid_nx_s;
      halted_r   <= halted_nx_s;
      misalign_r <= misalign_nx_s;
    end
  end

  assign bus.pc_o         = pc_r;
  assign bus.pc_valid     = valid_r;
  assign bus.epc_o        = epc_r;
  assign bus.misalign_err = misalign_r;
  assign bus.halted       = halted_r;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: vector table with expected post-edge outputs
// queued as a scoreboard, then a random advance/stall run and a bounded boot wait.
module tb_pc_unit;
  localparam int XLEN = 32;

  localparam logic [8:0] C_NONE = 9'b0_0000_0000;
  localparam logic [8:0] C_RST  = 9'b1_0000_0000;
  localparam logic [8:0] C_STL  = 9'b0_1000_0000;
  localparam logic [8:0] C_HLT  = 9'b0_0100_0000;
  localparam logic [8:0] C_RES  = 9'b0_0010_0000;
  localparam logic [8:0] C_BR   = 9'b0_0001_0000;
  localparam logic [8:0] C_JMP  = 9'b0_0000_1000;
  localparam logic [8:0] C_TRP  = 9'b0_0000_0100;
  localparam logic [8:0] C_TRT  = 9'b0_0000_0010;
  localparam logic [8:0] C_RDY  = 9'b0_0000_0001;

  typedef struct {
    logic [8:0]  ctl;
    logic [31:0] bt;
    logic [31:0] jt;
    logic [31:0] pc;
    logic        valid;
    logic [31:0] epc;
    logic        mis;
    logic        hlt;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic        valid;
    logic [31:0] epc;
    logic        mis;
    logic        hlt;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_vec  = 0;
  int   n_miss = 0;
  vec_t vecs[$];
  exp_t exp_q[$];

  always #5 clk = ~clk;

  pc_unit_if #(.XLEN(XLEN)) bus();

  pc_unit #(
    .XLEN(XLEN), .RESET_VECTOR(32'h0000_0000), .TRAP_VECTOR(32'h0000_0100),
    .INC(4), .ALIGN_BITS(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  function automatic vec_t mk(input logic [8:0] c, input logic [31:0] bt, input logic [31:0] jt,
                              input logic [31:0] pc, input logic v, input logic [31:0] epc,
                              input logic mis, input logic hlt);
    vec_t t;
    t.ctl = c; t.bt = bt; t.jt = jt; t.pc = pc; t.valid = v; t.epc = epc; t.mis = mis; t.hlt = hlt;
    return t;
  endfunction

  task automatic apply(input int id, input vec_t t);
    exp_t e;
    exp_t got;
    @(negedge clk);
    rst               = t.ctl[8];
    bus.stall         = t.ctl[7];
    bus.halt          = t.ctl[6];
    bus.resume        = t.ctl[5];
    bus.branch_taken  = t.ctl[4];
    bus.jump          = t.ctl[3];
    bus.trap          = t.ctl[2];
    bus.trap_ret      = t.ctl[1];
    bus.pc_ready      = t.ctl[0];
    bus.branch_target = t.bt;
    bus.jump_target   = t.jt;
    e.pc = t.pc; e.valid = t.valid; e.epc = t.epc; e.mis = t.mis; e.hlt = t.hlt;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    got = exp_q.pop_front();
    n_vec++;
    if (bus.pc_o !== got.pc || bus.pc_valid !== got.valid || bus.epc_o !== got.epc ||
        bus.misalign_err !== got.mis || bus.halted !== got.hlt) begin
      n_miss++;
      $display("FAIL vec%0d: got pc=%h valid=%b epc=%h mis=%b halted=%b, need pc=%h valid=%b epc=%h mis=%b halted=%b",
               id, bus.pc_o, bus.pc_valid, bus.epc_o, bus.misalign_err, bus.halted,
               got.pc, got.valid, got.epc, got.mis, got.hlt);
    end
  endtask

  initial begin
    logic [31:0] model_pc;
    logic        r, s;
    int          cnt;
    rst = 1'b1;
    bus.stall = 1'b0; bus.halt = 1'b0; bus.resume = 1'b0; bus.branch_taken = 1'b0;
    bus.jump = 1'b0; bus.trap = 1'b0; bus.trap_ret = 1'b0; bus.pc_ready = 1'b0;
    bus.branch_target = 32'h0; bus.jump_target = 32'h0;

    // reset, boot, increment, stall
    vecs.push_back(mk(C_RST, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0));
    vecs.push_back(mk(C_RST, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0));
    vecs.push_back(mk(C_RST, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0));
    vecs.push_back(mk(C_RDY, 32'h0, 32'h0, 32'h0, 1'b1, 32'h0, 1'b0, 1'b0));
    vecs.push_back(mk(C_RDY, 32'h0, 32'h0, 32'h4, 1'b1, 32'h0, 1'b0, 1'b0));
    vecs.push_back(mk(C_RDY, 32'h0, 32'h0, 32'h8, 1'b1, 32'h0, 1'b0, 1'b0));
    vecs.push_back(mk(C_RDY, 32'h0, 32'h0, 32'hC, 1'b1, 32'h0, 1'b0, 1'b0));
    vecs.push_back(mk(C_RDY, 32'h0, 32'h0, 32'h10, 1'b1, 32'h0, 1'b0, 1'b0));
    vecs.push_back(mk(C_STL | C_RDY, 32'h0, 32'h0, 32'h10, 1'b1, 32'h0, 1'b0, 1'b0));
    vecs.push_back(mk(C_RDY, 32'h0, 32'h0, 32'h14, 1'b1, 32'h0, 1'b0, 1'b0));
    vecs.push_back(mk(C_NONE, 32'h0, 32'h0, 32'h14, 1'b1, 32'h0, 1'b0, 1'b0));
    // jump beats branch; redirect ignores stall
    vecs.push_back(mk(C_JMP, 32'h0, 32'h40, 32'h40, 1'b1, 32'h0, 1'b0, 1'b0));
    vecs.push_back(mk(C_JMP | C_BR | C_RDY, 32'h80, 32'h200, 32'h200, 1'b1, 32'h0, 1'b0, 1'b0));
    vecs.push_back(mk(C_JMP | C_STL, 32'h0, 32'h44, 32'h44, 1'b1, 32'h0, 1'b0, 1'b0));
    // misaligned branch -> trap, then return
    vecs.push_back(mk(C_BR, 32'h81, 32'h0, 32'h100, 1'b1, 32'h44, 1'b1, 1'b0));
    vecs.push_back(mk(C_TRT, 32'h0, 32'h0, 32'h44, 1'b1, 32'h44, 1'b0, 1'b0));
    vecs.push_back(mk(C_RDY, 32'h0, 32'h0, 32'h48, 1'b1, 32'h44, 1'b0, 1'b0));
    vecs.push_back(mk(C_TRP | C_TRT, 32'h0, 32'h0, 32'h100, 1'b1, 32'h48, 1'b0, 1'b0));
    vecs.push_back(mk(C_TRT, 32'h0, 32'h0, 32'h48, 1'b1, 32'h48, 1'b0, 1'b0));
    vecs.push_back(mk(C_JMP, 32'h0, 32'h202, 32'h100, 1'b1, 32'h48, 1'b1, 1'b0));
    vecs.push_back(mk(C_NONE, 32'h0, 32'h0, 32'h100, 1'b1, 32'h48, 1'b0, 1'b0));
    // wrap
    vecs.push_back(mk(C_JMP | C_RDY, 32'h0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b1, 32'h48, 1'b0, 1'b0));
    vecs.push_back(mk(C_RDY, 32'h0, 32'h0, 32'h0, 1'b1, 32'h48, 1'b0, 1'b0));
    // halt / resume / trap in halt / reset in halt
    vecs.push_back(mk(C_JMP, 32'h0, 32'h20, 32'h20, 1'b1, 32'h48, 1'b0, 1'b0));
    vecs.push_back(mk(C_HLT | C_RDY, 32'h0, 32'h0, 32'h20, 1'b0, 32'h48, 1'b0, 1'b1));
    vecs.push_back(mk(C_RDY, 32'h0, 32'h0, 32'h20, 1'b0, 32'h48, 1'b0, 1'b1));
    vecs.push_back(mk(C_HLT | C_RES, 32'h0, 32'h0, 32'h20, 1'b1, 32'h48, 1'b0, 1'b0));
    vecs.push_back(mk(C_HLT | C_JMP, 32'h0, 32'h30, 32'h30, 1'b1, 32'h48, 1'b0, 1'b0));
    vecs.push_back(mk(C_HLT, 32'h0, 32'h0, 32'h30, 1'b0, 32'h48, 1'b0, 1'b1));
    vecs.push_back(mk(C_TRP, 32'h0, 32'h0, 32'h100, 1'b1, 32'h30, 1'b0, 1'b0));
    vecs.push_back(mk(C_HLT, 32'h0, 32'h0, 32'h100, 1'b0, 32'h30, 1'b0, 1'b1));
    vecs.push_back(mk(C_RST, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0));
    vecs.push_back(mk(C_NONE, 32'h0, 32'h0, 32'h0, 1'b1, 32'h0, 1'b0, 1'b0));
    vecs.push_back(mk(C_RDY, 32'h0, 32'h0, 32'h4, 1'b1, 32'h0, 1'b0, 1'b0));
    vecs.push_back(mk(C_RST | C_JMP, 32'h0, 32'h200, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0));
    vecs.push_back(mk(C_RDY, 32'h0, 32'h0, 32'h0, 1'b1, 32'h0, 1'b0, 1'b0));
    vecs.push_back(mk(C_TRT, 32'h0, 32'h0, 32'h0, 1'b1, 32'h0, 1'b0, 1'b0));

    for (int i = 0; i < vecs.size(); i++) begin
      apply(i, vecs[i]);
    end

    // random ready/stall mix from pc 0 with a simple advance model
    model_pc = 32'h0;
    for (int i = 0; i < 24; i++) begin
      r = 1'($urandom_range(0, 1));
      s = 1'($urandom_range(0, 1));
      if (r && !s) model_pc = model_pc + 32'd4;
      apply(100 + i, mk({1'b0, s, 6'b0, r}, 32'h0, 32'h0, model_pc, 1'b1, 32'h0, 1'b0, 1'b0));
    end

    // bounded wait for pc_valid after a fresh reset
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    while (!bus.pc_valid && cnt < 4) begin
      @(negedge clk);
      cnt++;
    end
    n_vec++;
    if (cnt != 1) begin
      n_miss++;
      $display("FAIL boot_wait: pc_valid rose after %0d cycles, need 1", cnt);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
